// File: rtl/trace_writer_if.sv
// Core-style data-memory request/grant port used by the trace writer to
// store records; master drives the request, slave returns grant/completion.
interface trace_writer_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                      data_req_o;
  logic [ADDR_WIDTH-1:0]     data_addr_o;
  logic                      data_we_o;
  logic [DATA_WIDTH/8-1:0]   data_be_o;
  logic [DATA_WIDTH-1:0]     data_wdata_o;
  logic                      data_gnt_i;
  logic                      data_rvalid_i;

  modport master (
    output data_req_o,
    output data_addr_o,
    output data_we_o,
    output data_be_o,
    output data_wdata_o,
    input  data_gnt_i,
    input  data_rvalid_i
  );

  modport slave (
    input  data_req_o,
    input  data_addr_o,
    input  data_we_o,
    input  data_be_o,
    input  data_wdata_o,
    output data_gnt_i,
    output data_rvalid_i
  );
endinterface

// File: rtl/trace_writer.sv
// Trace record consumer: queues completed trace records in a small FIFO and
// writes them word-by-word into a circular trace buffer through a memory port.
module trace_writer #(
  parameter int unsigned              ADDR_WIDTH   = 32,
  parameter int unsigned              DATA_WIDTH   = 32,
  parameter int unsigned              RECORD_WORDS = 4,
  parameter int unsigned              FIFO_DEPTH   = 4,
  parameter logic [ADDR_WIDTH-1:0]    BASE_ADDR    = 'h0001_0000,
  parameter int unsigned              BUF_RECORDS  = 256
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 enable_i,
  input  logic                                 trace_data_ready,
  input  logic [RECORD_WORDS*DATA_WIDTH-1:0]   trace_data_i,
  trace_writer_if.master                       mem,
  output logic                                 busy_o,
  output logic                                 overflow_o,
  output logic [15:0]                          dropped_o,
  output logic [31:0]                          records_written_o
);

  localparam int unsigned BYTES  = DATA_WIDTH / 8;
  localparam int unsigned REC_W  = RECORD_WORDS * DATA_WIDTH;
  localparam int unsigned WIDX_W = (RECORD_WORDS > 1) ? $clog2(RECORD_WORDS) : 1;
  localparam int unsigned PTR_W  = (BUF_RECORDS > 1) ? $clog2(BUF_RECORDS) : 1;
  localparam int unsigned FA_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = FA_W + 1;

  localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(RECORD_WORDS - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]            r_state;
  logic [WIDX_W-1:0]     r_word_idx;
  logic [PTR_W-1:0]      r_wr_ptr;

  logic [REC_W-1:0]      r_fifo [FIFO_DEPTH];
  logic [FA_W-1:0]       r_fifo_rd;
  logic [FA_W-1:0]       r_fifo_wr;
  logic [CNT_W-1:0]      r_fifo_cnt;

  logic                  r_req;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_we;
  logic [BYTES-1:0]      r_be;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_busy;
  logic                  r_overflow;
  logic [15:0]           r_dropped;
  logic [31:0]           r_written;

  logic [1:0]            w_next_state;
  logic [WIDX_W-1:0]     w_next_word_idx;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_capture;
  logic                  w_push;
  logic                  w_drop;
  logic [CNT_W-1:0]      w_next_cnt;
  logic                  w_next_req;
  logic [ADDR_WIDTH-1:0] w_word_lin;
  logic [ADDR_WIDTH-1:0] w_next_addr;
  logic [REC_W-1:0]      w_head;
  logic [DATA_WIDTH-1:0] w_head_words [RECORD_WORDS];
  logic [DATA_WIDTH-1:0] w_next_wdata;

  // Write FSM: one outstanding request, one word per REQ/WAIT round trip
  always_comb begin
    w_next_state    = r_state;
    w_next_word_idx = r_word_idx;
    w_pop           = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_fifo_cnt != '0) begin
          w_next_state    = S_REQ;
          w_next_word_idx = '0;
        end
      end
      S_REQ: begin
        if (mem.data_gnt_i) begin
          w_next_state = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem.data_rvalid_i) begin
          if (r_word_idx == LAST_WORD) begin
            w_pop           = 1'b1;
            w_next_state    = S_IDLE;
            w_next_word_idx = '0;
          end else begin
            w_next_word_idx = r_word_idx + WIDX_W'(1);
            w_next_state    = S_REQ;
          end
        end
      end
      default: begin
        w_next_state    = S_IDLE;
        w_next_word_idx = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_word_idx <= '0;
    end else begin
      r_state    <= w_next_state;
      r_word_idx <= w_next_word_idx;
    end
  end

  // A full FIFO popping on the same edge frees the slot the push lands in
  always_comb begin
    w_full    = (r_fifo_cnt == FULL_CNT);
    w_capture = trace_data_ready & enable_i;
    w_push    = w_capture & (~w_full | w_pop);
    w_drop    = w_capture & w_full & ~w_pop;
    w_next_cnt = r_fifo_cnt;
    case ({w_push, w_pop})
      2'b10:   w_next_cnt = r_fifo_cnt + CNT_W'(1);
      2'b01:   w_next_cnt = r_fifo_cnt - CNT_W'(1);
      default: w_next_cnt = r_fifo_cnt;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fifo_rd  <= '0;
      r_fifo_wr  <= '0;
      r_fifo_cnt <= '0;
    end else begin
      r_fifo_cnt <= w_next_cnt;
      if (w_push) r_fifo_wr <= r_fifo_wr + FA_W'(1);
      if (w_pop)  r_fifo_rd <= r_fifo_rd + FA_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_fifo_wr] <= trace_data_i;
  end

  // Buffer position and host-visible status counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_written  <= '0;
      r_overflow <= 1'b0;
      r_dropped  <= '0;
    end else begin
      if (w_pop) begin
        r_wr_ptr  <= r_wr_ptr + PTR_W'(1);
        r_written <= r_written + 32'd1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_dropped != 16'hFFFF) r_dropped <= r_dropped + 16'd1;
      end
    end
  end

  // Bus values are computed for the state being entered so they are registered
  always_comb begin
    w_head = r_fifo[r_fifo_rd];
    for (int unsigned w = 0; w < RECORD_WORDS; w++) begin
      w_head_words[w] = w_head[w*DATA_WIDTH +: DATA_WIDTH];
    end
    w_next_req   = (w_next_state == S_REQ);
    w_word_lin   = ADDR_WIDTH'(r_wr_ptr) * ADDR_WIDTH'(RECORD_WORDS)
                 + ADDR_WIDTH'(w_next_word_idx);
    w_next_addr  = BASE_ADDR + w_word_lin * ADDR_WIDTH'(BYTES);
    w_next_wdata = w_head_words[w_next_word_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req   <= 1'b0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_be    <= '0;
      r_wdata <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_req   <= w_next_req;
      r_addr  <= w_next_req ? w_next_addr : '0;
      r_we    <= w_next_req;
      r_be    <= w_next_req ? '1 : '0;
      r_wdata <= w_next_req ? w_next_wdata : '0;
      r_busy  <= (w_next_cnt != '0) || (w_next_state != S_IDLE);
    end
  end

  assign mem.data_req_o    = r_req;
  assign mem.data_addr_o   = r_addr;
  assign mem.data_we_o     = r_we;
  assign mem.data_be_o     = r_be;
  assign mem.data_wdata_o  = r_wdata;
  assign busy_o            = r_busy;
  assign overflow_o        = r_overflow;
  assign dropped_o         = r_dropped;
  assign records_written_o = r_written;

endmodule

// File: tb/tb_trace_writer.sv
// Self-checking bench for trace_writer: memory responder with scoreboard,
// table-driven single-record vectors and hand-written multi-cycle scenarios.
module tb_trace_writer;
  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned RW   = 4;
  localparam int unsigned BUFR = 256;
  localparam logic [31:0] BASE = 32'h0001_0000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable_i;
  logic         trace_data_ready;
  logic [127:0] trace_data_i;
  logic         busy_o;
  logic         overflow_o;
  logic [15:0]  dropped_o;
  logic [31:0]  records_written_o;

  always #5 clk = ~clk;

  trace_writer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem ();

  trace_writer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RECORD_WORDS(RW), .FIFO_DEPTH(4),
    .BASE_ADDR(BASE), .BUF_RECORDS(BUFR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable_i),
    .trace_data_ready(trace_data_ready), .trace_data_i(trace_data_i),
    .mem(mem), .busy_o(busy_o), .overflow_o(overflow_o),
    .dropped_o(dropped_o), .records_written_o(records_written_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  int          model_ptr = 0;

  logic gnt_global = 1'b1;
  int   stall_target = -1;
  int   stall_n = 0;
  int   stall_seen = 0;
  int   req_cnt = 0;
  logic last_flag = 1'b0;

  typedef struct {
    logic [127:0] rec;
    logic [31:0]  exp_written;
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_expect(input logic [127:0] rec);
    for (int w = 0; w < int'(RW); w++) begin
      exp_addr_q.push_back(BASE + 32'((model_ptr * int'(RW) + w) * 4));
      exp_data_q.push_back(rec[w*32 +: 32]);
    end
    model_ptr = (model_ptr + 1) % int'(BUFR);
  endtask

  task automatic send(input logic [127:0] rec);
    push_expect(rec);
    @(negedge clk);
    trace_data_ready = 1'b1;
    trace_data_i     = rec;
    @(negedge clk);
    trace_data_ready = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while ((busy_o || exp_addr_q.size() != 0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (k >= budget) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_idle_timeout: busy=%0d pending_writes=%0d, required idle", busy_o, exp_addr_q.size());
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    exp_addr_q.delete();
    exp_data_q.delete();
    model_ptr = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Memory responder: grant with optional stall, rvalid one cycle after grant
  logic        r_pending = 1'b0;
  logic [31:0] cur_a, cur_d;
  int          cyc, wait_left;
  logic        is_tgt, acc, acc_last;
  logic [4:0]  acc_webe;
  initial begin
    mem.data_gnt_i    = 1'b0;
    mem.data_rvalid_i = 1'b0;
    wait_left = 0;
    forever begin
      @(negedge clk);
      if (mem.data_req_o) begin
        if (!r_pending) begin
          r_pending = 1'b1;
          cur_a     = mem.data_addr_o;
          cur_d     = mem.data_wdata_o;
          cyc       = 0;
          is_tgt    = (req_cnt == stall_target);
          wait_left = is_tgt ? stall_n : 0;
          req_cnt++;
        end else begin
          chk("req_addr_stable", 64'(mem.data_addr_o), 64'(cur_a));
          chk("req_wdata_stable", 64'(mem.data_wdata_o), 64'(cur_d));
        end
        cyc++;
        mem.data_gnt_i = gnt_global && (wait_left == 0);
        if (wait_left > 0) wait_left--;
      end else begin
        r_pending      = 1'b0;
        mem.data_gnt_i = 1'b0;
        chk("idle_bus_zero", 64'({mem.data_addr_o, mem.data_wdata_o, mem.data_we_o, mem.data_be_o}), 64'(0));
      end
      acc      = mem.data_req_o && mem.data_gnt_i;
      acc_last = acc && (cur_a[3:2] == 2'b11);
      acc_webe = {mem.data_we_o, mem.data_be_o};
      @(posedge clk);
      #1;
      mem.data_rvalid_i = acc;
      last_flag         = acc_last;
      if (acc) begin
        r_pending = 1'b0;
        if (is_tgt) stall_seen = cyc;
        chk("write_we_be", 64'(acc_webe), 64'(5'h1F));
        if (exp_addr_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, required no write", cur_a, cur_d);
        end else begin
          chk("write_addr", 64'(cur_a), 64'(exp_addr_q.pop_front()));
          chk("write_data", 64'(cur_d), 64'(exp_data_q.pop_front()));
        end
      end
    end
  end

  initial begin
    logic [127:0] rec;
    bit found;
    rst_n            = 1'b0;
    enable_i         = 1'b1;
    trace_data_ready = 1'b0;
    trace_data_i     = '0;

    vecs[0] = '{rec: 128'h00000004_00000003_00000002_00000001, exp_written: 32'd1};
    vecs[1] = '{rec: {128{1'b1}},                             exp_written: 32'd2};
    vecs[2] = '{rec: 128'hDEADBEEF_0BADF00D_12345678_A5A5A5A5, exp_written: 32'd3};
    vecs[3] = '{rec: 128'h0,                                  exp_written: 32'd4};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req", 64'(mem.data_req_o), 64'(0));
    chk("rst_addr", 64'(mem.data_addr_o), 64'(0));
    chk("rst_wdata", 64'(mem.data_wdata_o), 64'(0));
    chk("rst_we_be", 64'({mem.data_we_o, mem.data_be_o}), 64'(0));
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_overflow", 64'(overflow_o), 64'(0));
    chk("rst_dropped", 64'(dropped_o), 64'(0));
    chk("rst_written", 64'(records_written_o), 64'(0));
    rst_n = 1'b1;

    // Single records with immediate grant, latency and completion counts
    for (int i = 0; i < 4; i++) begin
      send(vecs[i].rec);
      chk("lat_req_low_after_capture", 64'(mem.data_req_o), 64'(0));
      chk("busy_after_capture", 64'(busy_o), 64'(1));
      @(negedge clk);
      chk("lat_req_high_next_cycle", 64'(mem.data_req_o), 64'(1));
      wait_idle(100);
      chk("vec_records_written", 64'(records_written_o), 64'(vecs[i].exp_written));
      chk("vec_busy_end", 64'(busy_o), 64'(0));
    end

    // Grant held low for 5 cycles on word 2
    stall_target = req_cnt + 2;
    stall_n      = 5;
    send(128'h44444444_33333333_22222222_11111111);
    wait_idle(100);
    chk("stall_req_cycles", 64'(stall_seen), 64'(6));
    chk("stall_records_written", 64'(records_written_o), 64'(5));
    stall_target = -1;

    // Six back-to-back strobes with grant held off: four queue, two drop
    gnt_global = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rec = {4{32'(32'h100 + i)}};
      trace_data_ready = 1'b1;
      trace_data_i     = rec;
      if (i < 4) push_expect(rec);
    end
    @(negedge clk);
    trace_data_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("ovf_dropped", 64'(dropped_o), 64'(2));
    chk("ovf_overflow", 64'(overflow_o), 64'(1));
    chk("ovf_no_writes_yet", 64'(exp_addr_q.size()), 64'(16));
    gnt_global = 1'b1;
    wait_idle(200);
    chk("ovf_records_written", 64'(records_written_o), 64'(9));

    // Full FIFO: strobe lands on the pop edge and must be accepted
    gnt_global = 1'b0;
    for (int i = 0; i < 4; i++) send({4{32'(32'h200 + i)}});
    gnt_global = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(posedge clk);
      #2;
      if (mem.data_rvalid_i && last_flag) found = 1'b1;
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("FAIL coincide_pop_timeout: no final rvalid seen, required one");
    end
    rec = {4{32'h0000_0300}};
    push_expect(rec);
    trace_data_ready = 1'b1;
    trace_data_i     = rec;
    @(posedge clk);
    #1;
    trace_data_ready = 1'b0;
    chk("coincide_dropped", 64'(dropped_o), 64'(2));
    wait_idle(300);
    chk("coincide_records_written", 64'(records_written_o), 64'(14));

    // Reset in the middle of word 1 of record 0
    do_reset();
    send(128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000);
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      @(posedge clk);
      #3;
      if (mem.data_req_o && mem.data_addr_o == BASE + 32'd4) found = 1'b1;
    end
    chk("midrst_word1_seen", 64'(found), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("midrst_req", 64'(mem.data_req_o), 64'(0));
    chk("midrst_bus", 64'({mem.data_addr_o, mem.data_wdata_o, mem.data_we_o, mem.data_be_o}), 64'(0));
    chk("midrst_status", 64'({busy_o, overflow_o, dropped_o}), 64'(0));
    chk("midrst_written", 64'(records_written_o), 64'(0));
    exp_addr_q.delete();
    exp_data_q.delete();
    model_ptr = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(128'hBBBB0003_BBBB0002_BBBB0001_BBBB0000);
    wait_idle(100);
    chk("midrst_after_written", 64'(records_written_o), 64'(1));

    // 257 records: the last one wraps to the buffer base
    do_reset();
    for (int i = 0; i < 257; i++) begin
      send({32'(i*4+3), 32'(i*4+2), 32'(i*4+1), 32'(i*4)});
      wait_idle(100);
    end
    chk("wrap_records_written", 64'(records_written_o), 64'(257));
    chk("wrap_overflow", 64'(overflow_o), 64'(0));
    chk("wrap_dropped", 64'(dropped_o), 64'(0));

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
